mini_fpga_fabric_top: RTL and testbench

- Small bitstream-configurable FPGA fabric: NUM_LUT LUT4 cells, each with an optional flip-flop, fully connected to NUM_IO pads through configurable input and output multiplexers.
- Configuration memory is one serial scan chain (ccff_head to ccff_tail) shifted on clk.
- Top level of the programmable fabric. Application logic (for example a 1-bit OR) is mapped onto it purely by bitstream.

---
 rtl/mini_fpga_fabric_top_pkg.sv | 52 +++++
 rtl/fabric_lut4_cell.sv | 45 ++++
 rtl/mini_fpga_fabric_top.sv | 90 +++++++++
 tb/tb_mini_fpga_fabric_top.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mini_fpga_fabric_top_pkg.sv
// Shared field layout, chain-length helpers and source decode for the mini FPGA fabric.
// FABRIC_FF_INIT_EN adds a per-LUT init bit (after byp) that sets the FF reset value.
package mini_fpga_pkg;

  localparam int unsigned TRUTH_W = 16;
  localparam int unsigned NUM_SEL = 4;
  localparam int unsigned SEL_MAX = 8;
  localparam int unsigned MAX_SRC = 1 << SEL_MAX;

`ifdef FABRIC_FF_INIT_EN
  localparam int unsigned INIT_W = 1;
`else
  localparam int unsigned INIT_W = 0;
`endif

  typedef logic [SEL_MAX-1:0] src_idx_t;

  typedef struct packed {
    logic [TRUTH_W-1:0]         truth;
    src_idx_t [NUM_SEL-1:0]     sel;
    logic                       byp;
`ifdef FABRIC_FF_INIT_EN
    logic                       init;
`endif
  } lut_cfg_t;

  function automatic int unsigned lut_cfg_w(input int unsigned selw);
    return TRUTH_W + NUM_SEL * selw + 1 + INIT_W;
  endfunction

  function automatic int unsigned pad_cfg_w(input int unsigned selw);
    return selw + 1;
  endfunction

  function automatic int unsigned cfg_len(input int unsigned num_lut,
                                          input int unsigned num_io,
                                          input int unsigned selw);
    return num_lut * lut_cfg_w(selw) + num_io * pad_cfg_w(selw);
  endfunction

  // Indices past the last real source read as constant 0.
  function automatic logic src_is_const(input src_idx_t s, input int unsigned num_src);
    return 32'(s) >= num_src;
  endfunction

  function automatic logic src_pick(input logic [MAX_SRC-1:0] bus,
                                    input src_idx_t s,
                                    input int unsigned num_src);
    return src_is_const(s, num_src) ? 1'b0 : bus[s];
  endfunction

endpackage

// File: rtl/fabric_lut4_cell.sv
// One LUT4 cell: four source muxes, 16-entry truth table, user FF and bypass select.
// With FABRIC_FF_INIT_EN the FF resets to the configured init bit instead of 0.
module fabric_lut4_cell
  import mini_fpga_pkg::*;
#(
  parameter int unsigned NUM_SRC = 12
) (
  input  logic               clk,
  input  logic               global_resetn,
  input  lut_cfg_t           cfg,
  input  logic [NUM_SRC-1:0] src,
  output logic               lut_out
);

  logic [MAX_SRC-1:0] src_ext;
  logic [NUM_SEL-1:0] lut_in;
  logic               comb;
  logic               ff;

  assign src_ext = MAX_SRC'(src);

  always_comb begin
    lut_in = '0;
    for (int unsigned k = 0; k < NUM_SEL; k++) begin
      lut_in[k] = src_pick(src_ext, cfg.sel[k], NUM_SRC);
    end
  end

  assign comb = cfg.truth[lut_in];

  always_ff @(posedge clk or negedge global_resetn) begin
    if (!global_resetn) begin
`ifdef FABRIC_FF_INIT_EN
      ff <= cfg.init;
`else
      ff <= 1'b0;
`endif
    end else begin
      ff <= comb;
    end
  end

  assign lut_out = cfg.byp ? comb : ff;

endmodule

// File: rtl/mini_fpga_fabric_top.sv
// Programmable fabric top: serial config chain, NUM_LUT LUT4 cells and per-pad output muxes.
// FABRIC_FF_INIT_EN lengthens the chain by one init bit per LUT.
module mini_fpga_fabric_top
  import mini_fpga_pkg::*;
#(
  parameter int unsigned NUM_IO  = 8,
  parameter int unsigned NUM_LUT = 4,
  parameter int unsigned SELW    = 4
) (
  input  logic              clk,
  input  logic              global_resetn,
  input  logic              scan_en,
  input  logic              scan_mode,
  input  logic [2:0]        rwm,
  input  logic [NUM_IO-1:0] gfpga_pad_QL_PREIO_A2F,
  output logic [NUM_IO-1:0] gfpga_pad_QL_PREIO_F2A,
  output logic [NUM_IO-1:0] gfpga_pad_QL_PREIO_F2A_CLK,
  input  logic              ccff_head,
  output logic              ccff_tail
);

  localparam int unsigned NUM_SRC  = NUM_IO + NUM_LUT;
  localparam int unsigned LUT_W    = lut_cfg_w(SELW);
  localparam int unsigned PAD_W    = pad_cfg_w(SELW);
  localparam int unsigned PAD_BASE = NUM_LUT * LUT_W;
  localparam int unsigned L        = cfg_len(NUM_LUT, NUM_IO, SELW);

  logic [L-1:0]         cfg;
  logic [NUM_LUT-1:0]   lut_out;
  logic [NUM_SRC-1:0]   src;
  logic [MAX_SRC-1:0]   src_ext;
  logic                 unused_rwm;

  assign unused_rwm = ^rwm;

  // Config memory has no reset: a loaded bitstream survives global_resetn.
  always_ff @(posedge clk) begin
    if (scan_en) begin
      cfg <= {cfg[L-2:0], ccff_head};
    end
  end

  assign ccff_tail = cfg[L-1];

  assign src     = {lut_out, gfpga_pad_QL_PREIO_A2F};
  assign src_ext = MAX_SRC'(src);

  for (genvar k = 0; k < NUM_LUT; k++) begin : g_lut
    localparam int unsigned BASE    = k * LUT_W;
    localparam int unsigned BYP_POS = BASE + TRUTH_W + NUM_SEL * SELW;

    lut_cfg_t cell_cfg;

    always_comb begin
      cell_cfg       = '0;
      cell_cfg.truth = cfg[BASE +: TRUTH_W];
      for (int unsigned j = 0; j < NUM_SEL; j++) begin
        cell_cfg.sel[j] = src_idx_t'(cfg[BASE + TRUTH_W + j * SELW +: SELW]);
      end
      cell_cfg.byp = cfg[BYP_POS];
`ifdef FABRIC_FF_INIT_EN
      cell_cfg.init = cfg[BYP_POS + 1];
`endif
    end

    fabric_lut4_cell #(
      .NUM_SRC (NUM_SRC)
    ) u_cell (
      .clk           (clk),
      .global_resetn (global_resetn),
      .cfg           (cell_cfg),
      .src           (src),
      .lut_out       (lut_out[k])
    );
  end

  for (genvar i = 0; i < NUM_IO; i++) begin : g_pad
    localparam int unsigned PB = PAD_BASE + i * PAD_W;

    src_idx_t osel;
    logic     oe;

    assign osel = src_idx_t'(cfg[PB +: SELW]);
    assign oe   = cfg[PB + SELW];

    assign gfpga_pad_QL_PREIO_F2A[i]     = !scan_mode && oe && src_pick(src_ext, osel, NUM_SRC);
    assign gfpga_pad_QL_PREIO_F2A_CLK[i] = !scan_mode && oe;
  end

endmodule

// File: tb/tb_mini_fpga_fabric_top.sv
// Directed bench for mini_fpga_fabric_top with a scoreboard of expected pad/chain values.
module tb_mini_fpga_fabric_top;

  localparam int NUM_IO  = 8;
  localparam int NUM_LUT = 4;
  localparam int SELW    = 4;
`ifdef FABRIC_FF_INIT_EN
  localparam int LUT_W = 34;
`else
  localparam int LUT_W = 33;
`endif
  localparam int L = NUM_LUT * LUT_W + NUM_IO * (SELW + 1);

  logic              clk = 1'b0;
  logic              rst_n;
  logic              scan_en;
  logic              scan_mode;
  logic [2:0]        rwm;
  logic [NUM_IO-1:0] a2f;
  logic [NUM_IO-1:0] f2a;
  logic [NUM_IO-1:0] f2a_clk;
  logic              head;
  logic              tail;

  always #5 clk = ~clk;

  mini_fpga_fabric_top #(
    .NUM_IO  (NUM_IO),
    .NUM_LUT (NUM_LUT),
    .SELW    (SELW)
  ) dut (
    .clk                        (clk),
    .global_resetn              (rst_n),
    .scan_en                    (scan_en),
    .scan_mode                  (scan_mode),
    .rwm                        (rwm),
    .gfpga_pad_QL_PREIO_A2F     (a2f),
    .gfpga_pad_QL_PREIO_F2A     (f2a),
    .gfpga_pad_QL_PREIO_F2A_CLK (f2a_clk),
    .ccff_head                  (head),
    .ccff_tail                  (tail)
  );

  typedef struct {
    string      tag;
    logic [7:0] exp;
  } sb_t;

  sb_t        sb[$];
  int         checks = 0;
  int         errors = 0;
  logic [L-1:0] bits;

  task automatic push(input string tag, input logic [7:0] exp);
    sb.push_back('{tag, exp});
  endtask

  task automatic check(input logic [7:0] obs);
    sb_t e;
    checks++;
    assert (sb.size() != 0) else begin
      errors++;
      $error("FAIL sb_empty: observed %h, no expected entry", obs);
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      assert (obs === e.exp) else begin
        errors++;
        $error("FAIL %s: observed %h expected %h", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic set_lut(input int k, input logic [15:0] truth,
                         input logic [3:0] s0, input logic [3:0] s1,
                         input logic [3:0] s2, input logic [3:0] s3,
                         input logic byp);
    int b;
    b = k * LUT_W;
    bits[b +: 16]      = truth;
    bits[b + 16 +: 4]  = s0;
    bits[b + 20 +: 4]  = s1;
    bits[b + 24 +: 4]  = s2;
    bits[b + 28 +: 4]  = s3;
    bits[b + 32]       = byp;
  endtask

  task automatic set_pad(input int i, input logic [3:0] osel, input logic oe);
    int b;
    b = NUM_LUT * LUT_W + i * (SELW + 1);
    bits[b +: 4]  = osel;
    bits[b + 4]   = oe;
  endtask

  // Highest bit first so that bit 0 lands in CFG[0].
  task automatic shift_in();
    for (int i = L - 1; i >= 0; i--) begin
      head    = bits[i];
      scan_en = 1'b1;
      @(posedge clk);
      #1;
    end
    scan_en = 1'b0;
    head    = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n     = 1'b0;
    scan_en   = 1'b0;
    scan_mode = 1'b0;
    rwm       = 3'b101;
    a2f       = '0;
    head      = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // All-zero bitstream under reset
    bits = '0;
    shift_in();
    push("zero_f2a", 8'h00);      check(f2a);
    push("zero_f2a_clk", 8'h00);  check(f2a_clk);
    push("zero_tail", 8'h00);     check({7'b0, tail});

    // Chain pass-through: a single 1 after all zeros
    a2f     = 8'hFF;
    head    = 1'b1;
    scan_en = 1'b1;
    @(posedge clk);
    #1;
    head = 1'b0;
    for (int i = 1; i < L - 1; i++) begin
      @(posedge clk);
      #1;
    end
    push("chain_tail_early", 8'h00); check({7'b0, tail});
    push("chain_oe0_f2a", 8'h00);    check(f2a);
    @(posedge clk);
    #1;
    scan_en = 1'b0;
    push("chain_tail_rise", 8'h01);  check({7'b0, tail});
    push("chain_pad7_oe", 8'h80);    check(f2a_clk);
    push("chain_pad7_f2a", 8'h80);   check(f2a);

    // 1-bit OR, bypassed LUT
    a2f  = '0;
    bits = '0;
    set_lut(0, 16'hFFFE, 4'd0, 4'd1, 4'd15, 4'd15, 1'b1);
    set_pad(0, 4'd8, 1'b1);
    shift_in();
    rst_n = 1'b1;
    #1;
    for (int ab = 0; ab < 4; ab++) begin
      a2f = 8'(ab);
      #1;
      push($sformatf("or_ab%0d", ab), {7'b0, (ab != 0)});
      check(f2a);
    end
    push("or_f2a_clk", 8'h01); check(f2a_clk);

    // Bypass path ignores reset
    a2f   = 8'h03;
    rst_n = 1'b0;
    #1;
    push("or_in_reset", 8'h01); check(f2a);
    rst_n = 1'b1;

    // Safe mode
    a2f       = 8'h01;
    scan_mode = 1'b1;
    #1;
    push("safe_f2a", 8'h00);     check(f2a);
    push("safe_f2a_clk", 8'h00); check(f2a_clk);
    scan_mode = 1'b0;
    #1;
    push("safe_exit_f2a", 8'h01); check(f2a);

    // Registered path
    rst_n = 1'b0;
    bits  = '0;
    set_lut(0, 16'hFFFE, 4'd0, 4'd1, 4'd15, 4'd15, 1'b0);
    set_pad(0, 4'd8, 1'b1);
    shift_in();
    a2f = 8'h01;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    push("reg_pre_edge", 8'h01 & 8'h00); check(f2a);
    @(posedge clk);
    #1;
    push("reg_after_edge", 8'h01); check(f2a);
    a2f = 8'h00;
    #1;
    push("reg_hold", 8'h01); check(f2a);
    @(posedge clk);
    #1;
    push("reg_fall", 8'h00); check(f2a);
    a2f = 8'h02;
    @(posedge clk);
    #1;
    push("reg_rise_b", 8'h01); check(f2a);
    rst_n = 1'b0;
    #1;
    push("reg_async_rst", 8'h00); check(f2a);
    rst_n = 1'b1;
    #1;
    push("reg_release", 8'h00); check(f2a);

    // Constant-select sources: truth bit 0 chosen when every input is 0
    bits = '0;
    set_lut(0, 16'h0001, 4'd15, 4'd15, 4'd15, 4'd15, 1'b1);
    set_pad(0, 4'd8, 1'b1);
    set_pad(1, 4'd3, 1'b1);
    shift_in();
    a2f = 8'hFF;
    #1;
    push("const15_hi", 8'h03); check(f2a);
    a2f = 8'h00;
    #1;
    push("const15_lo", 8'h01); check(f2a);

    bits = '0;
    set_lut(0, 16'h0001, 4'd12, 4'd13, 4'd14, 4'd12, 1'b1);
    set_pad(0, 4'd8, 1'b1);
    shift_in();
    a2f = 8'hFF;
    #1;
    push("const12_14", 8'h01); check(f2a);

    bits = '0;
    set_lut(0, 16'h0002, 4'd15, 4'd15, 4'd15, 4'd15, 1'b1);
    set_pad(0, 4'd8, 1'b1);
    shift_in();
    #1;
    push("const_truth0_clear", 8'h00); check(f2a);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
